// File: rtl/accumulator.sv
// ----------------------------------------------------------------------------
// accumulator
//   Registered unsigned accumulator used as the summation stage behind a
//   multi-cycle MAC/compute array. On every enabled rising edge the
//   zero-extended input sample is added to the running sum.
//
// Parameters
//   IN_W     : width of the unsigned input sample
//   OUT_W    : width of the accumulator register / output
//   SATURATE : 0 = wrap modulo 2^OUT_W, 1 = clamp at 2^OUT_W-1
//
// Ports
//   clk   : system clock, state updates on the rising edge
//   reset : asynchronous active-high clear
//   en    : accumulate enable, sampled on the rising edge
//   in    : unsigned sample, added when en=1 (don't-care when en=0)
//   out   : accumulator value, driven straight from the register
// ----------------------------------------------------------------------------
module accumulator #(
    parameter int IN_W     = 5,
    parameter int OUT_W    = 14,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out
);

    // The zero-extension below needs at least one bit of headroom.
    if (IN_W >= OUT_W) begin : g_bad_width
        $error("accumulator: IN_W (%0d) must be less than OUT_W (%0d)", IN_W, OUT_W);
    end

    logic [OUT_W-1:0] acc_q;
    logic [OUT_W:0]   sum_ext;
    logic [OUT_W-1:0] acc_nxt;

    // One extra bit so the carry-out is visible to the overflow policy.
    assign sum_ext = {1'b0, acc_q} + {{(OUT_W + 1 - IN_W){1'b0}}, in};

    if (SATURATE) begin : g_sat
        assign acc_nxt = sum_ext[OUT_W] ? {OUT_W{1'b1}} : sum_ext[OUT_W-1:0];
    end else begin : g_wrap
        assign acc_nxt = sum_ext[OUT_W-1:0];
    end

    // Reset wins over en; 'in' is only consumed when en is high, so garbage
    // on it while idle never reaches the register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_nxt;
        end
    end

    assign out = acc_q;

endmodule

// File: tb/tb_accumulator.sv
module tb_accumulator;

    localparam int IN_W  = 5;
    localparam int OUT_W = 14;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             en    = 1'b0;
    logic [IN_W-1:0]  in    = '0;
    logic [OUT_W-1:0] out_w;
    logic [OUT_W-1:0] out_s;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    accumulator #(.IN_W(IN_W), .OUT_W(OUT_W), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .in(in), .out(out_w)
    );

    accumulator #(.IN_W(IN_W), .OUT_W(OUT_W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .in(in), .out(out_s)
    );

    task automatic test_reset;
        #1;
        total_cnt++;
        if (out_w !== 14'd0 || out_s !== 14'd0)
            $display("FAIL reset_t0: wrap=%0d sat=%0d expected 0", out_w, out_s);
        else pass_cnt++;
        en = 1'b1;
        in = 5'd31;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_w !== 14'd0 || out_s !== 14'd0)
                $display("FAIL reset_hold[%0d]: wrap=%0d sat=%0d expected 0", i, out_w, out_s);
            else pass_cnt++;
        end
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_w !== 14'd0)
                $display("FAIL reset_release[%0d]: got %0d expected 0", i, out_w);
            else pass_cnt++;
        end
    endtask

    task automatic test_sequence;
        logic [OUT_W-1:0] exp_tbl [6] = '{14'd10, 14'd21, 14'd33, 14'd46, 14'd60, 14'd75};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en = 1'b1;
            in = 5'(10 + i);
            @(posedge clk); #1;
            total_cnt++;
            if (out_w !== exp_tbl[i] || out_s !== exp_tbl[i])
                $display("FAIL seq[%0d]: wrap=%0d sat=%0d expected %0d", i, out_w, out_s, exp_tbl[i]);
            else pass_cnt++;
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (out_w !== 14'd75)
            $display("FAIL seq_hold: got %0d expected 75", out_w);
        else pass_cnt++;
        // in=0 with en=1 must leave the sum unchanged
        @(negedge clk);
        en = 1'b1;
        in = 5'd0;
        @(posedge clk); #1;
        total_cnt++;
        if (out_w !== 14'd75)
            $display("FAIL seq_zero_in: got %0d expected 75", out_w);
        else pass_cnt++;
    endtask

    task automatic test_hold_garbage;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = 1'b0;
            in = (i < 2) ? 'x : 5'd31;
            @(posedge clk); #1;
            total_cnt++;
            if (out_w !== 14'd75)
                $display("FAIL hold_garbage[%0d]: got %0d expected 75", i, out_w);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
        in    = 5'd31;
        // 528 * 31 = 16368, still below 2^14 on both instances
        repeat (528) @(posedge clk);
        #1;
        total_cnt++;
        if (out_w !== 14'd16368 || out_s !== 14'd16368)
            $display("FAIL wrap_pre: wrap=%0d sat=%0d expected 16368", out_w, out_s);
        else pass_cnt++;
        // 529th sample: 16399 -> wraps to 15 / clamps at 16383
        @(posedge clk); #1;
        total_cnt++;
        if (out_w !== 14'd15)
            $display("FAIL wrap_mod: got %0d expected 15", out_w);
        else pass_cnt++;
        total_cnt++;
        if (out_s !== 14'd16383)
            $display("FAIL sat_clamp: got %0d expected 16383", out_s);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (out_s !== 14'd16383)
            $display("FAIL sat_stay: got %0d expected 16383", out_s);
        else pass_cnt++;
        total_cnt++;
        if (out_w !== 14'd108)
            $display("FAIL wrap_cont: got %0d expected 108", out_w);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = 1'b1;
            in = 5'(10 + i);
            @(posedge clk);
        end
        #1;
        total_cnt++;
        if (out_w !== 14'd46)
            $display("FAIL async_pre: got %0d expected 46", out_w);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt++;
        if (out_w !== 14'd0 || out_s !== 14'd0)
            $display("FAIL async_clear: wrap=%0d sat=%0d expected 0", out_w, out_s);
        else pass_cnt++;
        #2;
        reset = 1'b0;
        en    = 1'b1;
        in    = 5'd7;
        @(posedge clk); #1;
        total_cnt++;
        if (out_w !== 14'd7 || out_s !== 14'd7)
            $display("FAIL async_first: wrap=%0d sat=%0d expected 7", out_w, out_s);
        else pass_cnt++;
    endtask

    task automatic test_reset_en_overlap;
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        in    = 5'd31;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (out_w !== 14'd0 || out_s !== 14'd0)
                $display("FAIL overlap[%0d]: wrap=%0d sat=%0d expected 0", i, out_w, out_s);
            else pass_cnt++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (out_w !== 14'd31)
            $display("FAIL overlap_release: got %0d expected 31", out_w);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_hold_garbage();
        test_wrap();
        test_async_reset();
        test_reset_en_overlap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
